// File: rtl/tt_um_mux_scan_if.sv
// Pin bundle of the tt_um_* user slot: enable, data/control inputs and the
// three output buses, with master (driver) and slave (tile) views.
interface tt_um_mux_scan_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_mux_scan.sv
// CH-channel 1-bit mux with manual select or auto-scan at DWELL cycles per channel.
// Optional input synchronizer enabled by defining MUX_SCAN_SYNC_EN.
module tt_um_mux_scan #(
    parameter int CH    = 8,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    tt_um_mux_scan_if.slave  bus
);

    typedef enum logic [1:0] {
        MANUAL  = 2'b00,
        SCAN    = 2'b01,
        HOLD    = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    localparam logic [2:0] CH_M1    = 3'(CH - 1);
    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    state_e        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          out_q;
    logic [2:0]    oidx_q;
    logic          wrap_q, wrap_d;
    logic [CH-1:0] data;
    logic [7:0]    data8;
    logic          scan_req, hold_req;
    logic          unused_bits;

    assign scan_req    = bus.uio_in[3];
    assign hold_req    = bus.uio_in[4];
    assign unused_bits = &{1'b0, bus.uio_in[7:5], bus.ui_in};

`ifdef MUX_SCAN_SYNC_EN
    logic [CH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else if (bus.ena) begin
            sync1_q <= bus.ui_in[CH-1:0];
            sync2_q <= sync1_q;
        end
    end

    assign data = sync2_q;
`else
    assign data = bus.ui_in[CH-1:0];
`endif

    assign data8 = 8'(data);

    // Next state, index and dwell counter are all decided by the current state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            MANUAL: begin
                state_d = scan_req ? SCAN : MANUAL;
                idx_d   = bus.uio_in[2:0] & CH_M1;
                cnt_d   = 8'd0;
            end
            SCAN: begin
                if (!scan_req)
                    state_d = MANUAL;
                else if (hold_req)
                    state_d = HOLD;
                if (cnt_q == DWELL_M1) begin
                    cnt_d = 8'd0;
                    idx_d = (idx_q == CH_M1) ? 3'd0 : idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (!scan_req)
                    state_d = MANUAL;
                else if (!hold_req)
                    state_d = SCAN;
            end
            default: begin
                state_d = MANUAL;
                idx_d   = bus.uio_in[2:0] & CH_M1;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Wrap fires as the displayed index rolls from the last channel back to 0.
    assign wrap_d = (state_q == SCAN) && (oidx_q == CH_M1) && (idx_q == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MANUAL;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            out_q   <= 1'b0;
            oidx_q  <= 3'd0;
            wrap_q  <= 1'b0;
        end else if (bus.ena) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            out_q   <= data8[idx_q];
            oidx_q  <= idx_q;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.uo_out  = {1'b0, wrap_q, state_q, oidx_q, out_q};
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;

endmodule

// File: doc/tt_um_mux_scan.md
# tt_um_mux_scan

Parametrised CH-channel, 1-bit multiplexer for the Tiny Tapeout user slot, succeeding the fixed 2:1 mux tile. It selects one bit of `ui_in` either from a manual index or from an auto-scan sequencer that rotates through channels with a programmable dwell time. The output is registered, along with the index that produced it and a wrap pulse. It sits directly behind the standard `tt_um_*` pin wrapper.

## Interface
- `CH`, default 8: number of channels taken from `ui_in[CH-1:0]`. Legal values are 2, 4 and 8.
- `DWELL`, default 4: cycles spent on each channel in scan mode. Legal range is 1..255.
- `clk`, in, 1: single clock; all state is on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `ena`, in, 1: clock enable. While low, every register (sync flops included) holds.
- `ui_in`, in, 8: channel data, bit i = channel i. Bits at and above CH are ignored.
- `uio_in`, in, 8:
  - [2:0] manual select;
  - [3] scan request;
  - [4] hold request;
  - [7:5] ignored.
- `uo_out`, out, 8:
  - [0] selected bit;
  - [3:1] index that produced bit 0;
  - [5:4] state;
  - [6] wrap pulse;
  - [7] constant 0.
- `uio_out`, out, 8: constant 0x00.
- `uio_oe`, out, 8: constant 0x00 (all bidirectional pins are inputs).

## Operation
- The state register has three values: MANUAL=2'b00, SCAN=2'b01, HOLD=2'b10. 2'b11 is illegal and recovers to MANUAL on the next edge.
- Transitions, evaluated each enabled edge:
  - any state → MANUAL when `uio_in[3]`=0 (highest priority);
  - MANUAL → SCAN when `uio_in[3]`=1;
  - SCAN → HOLD when `uio_in[4]`=1;
  - HOLD → SCAN when `uio_in[4]`=0.
- Index register `idx` (3 bits) and dwell counter `cnt` (8 bits):
  - MANUAL: `idx` ← `uio_in[2:0]` & (CH-1); `cnt` ← 0.
  - SCAN: if `cnt`==DWELL-1, then `cnt` ← 0 and `idx` ← (`idx`==CH-1) ? 0 : `idx`+1. Otherwise `cnt` ← `cnt`+1.
  - HOLD: `idx` and `cnt` frozen.
- MANUAL→SCAN starts from the current `idx` with `cnt`=0. HOLD→SCAN resumes the frozen `cnt`.
- Output stage, every enabled edge:
  - `out_q` ← data[`idx`];
  - `idx_q` ← `idx`;
  - `wrap_q` ← 1 iff `idx_q` goes from CH-1 to 0 while in SCAN.
- `uo_out[5:4]` shows the state register directly.
- With DWELL=1, `idx` advances every enabled SCAN edge.

## Timing
- Reset (async assert) forces: state=MANUAL, `idx`=0, `cnt`=0, `out_q`=0, `idx_q`=0, `wrap_q`=0, sync flops=0. Therefore `uo_out`=0x00.
- Release is synchronous to `clk`; the first enabled edge after release performs normal operation.
- Manual select latency: `uio_in[2:0]` is sampled at edge N into `idx`, and `uo_out[3:1]`/`uo_out[0]` reflect it after edge N+1.
- Data latency from `ui_in` to `uo_out[0]` is 1 cycle without the sync stage and 3 cycles with it.
- In SCAN, `uo_out[3:1]` holds each value for exactly DWELL enabled cycles. A full rotation takes CH×DWELL cycles.
- `uo_out[6]` is high for exactly one cycle, in the first cycle where `uo_out[3:1]` shows 0 after CH-1.
- Simultaneous `uio_in[3]`=0 and `uio_in[4]`=1 → MANUAL.
- Simultaneous `uio_in[3]`=1 and `uio_in[4]`=1 while in MANUAL → SCAN first, then HOLD on the next edge.
- `ena` low: outputs are stable and no counter advances. Edges with `ena` low do not count toward DWELL.

## Configuration
- `MUX_SCAN_SYNC_EN` defined: `ui_in[CH-1:0]` passes through a 2-flop synchronizer (reset to 0, gated by `ena`) before selection. Data latency is 3 cycles.
- `MUX_SCAN_SYNC_EN` undefined: the synchronizer is absent and `ui_in` feeds the selector directly. Data latency is 1 cycle.
- Control inputs (`uio_in`) are never synchronized in either build.

## Test plan
All scenarios use CH=8, DWELL=4 and no sync macro unless stated.
1. Reset: hold `rst_n`=0 with random inputs → `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0x00. Assert `rst_n` low mid-scan between edges → `uo_out` clears immediately.
2. Manual select: `ui_in`=0x20, `uio_in`=0x05 → after 2 edges `uo_out`=0x0B. Then `uio_in`=0x0D (scan request plus select 5), reached from MANUAL → state 01, scan starts at index 5.
3. Auto scan: from reset, `ui_in`=0x01, `uio_in`=0x08 → `uo_out[3:1]` steps 0,1,…,7,0, each value for 4 cycles. `uo_out[0]`=1 only while the index is 0. `uo_out[6]` pulses once per 32 cycles, on the 7→0 step.
4. Hold: in SCAN at `cnt`=2, set `uio_in`=0x18 for 10 cycles → index frozen, `uo_out[5:4]`=10. Clear to 0x08 → the index advances after 2 more cycles.
5. Enable gating: drop `ena` for 10 cycles mid-dwell → `uo_out` constant. Restore → the dwell completes with the remaining count.
6. Sync build (`MUX_SCAN_SYNC_EN`): manual index 3, toggle `ui_in[3]` 0→1 at edge N → `uo_out[0]` rises after edge N+2 (vs N without the macro).
